muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for the HI/LO arithmetic resource used by mult/multu/div/divu.
//  Sits beside EX: EX issues a start request with operands.
//  The block runs a shared-adder iterative engine and holds EX via stallreq until the
//  result is ready, then presents {hi,lo} for one cycle of HI/LO write-back.
// PARAMETERS
//  WIDTH   32  operand width (op_a, op_b, result_hi, result_lo)
//  CNT_W   6   iteration counter width; must hold WIDTH
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  start_div    in   1      EX holds div/divu; level, held while EX is stalled
//  start_mul    in   1      EX holds mult/multu; level, held while EX is stalled
//  signed_op    in   1      1 = div/mult, 0 = divu/multu
//  op_a         in   WIDTH  rs value (dividend / multiplicand)
//  op_b         in   WIDTH  rt value (divisor / multiplier)
//  annul        in   1      flush: abort any operation in flight
//  stallreq     out  1      stall request to the stall controller (EX and earlier stop)
//  busy         out  1      engine occupied (RUN states)
//  result_valid out  1      1-cycle pulse: result_hi/result_lo valid
//  result_hi    out  WIDTH  remainder (div) or product[63:32] (mul)
//  result_lo    out  WIDTH  quotient (div) or product[31:0] (mul)
// BEHAVIOUR
//  Reset: state=IDLE; stallreq=0, busy=0, result_valid=0, result_hi=0, result_lo=0, counter=0.
//  States: IDLE, DIV_RUN, MUL_RUN, DONE.
//  start_* is sampled only in IDLE. It is ignored in RUN and DONE.
//    Holding start through DONE therefore never re-launches the same instruction.
//  Start conflict: start_div has priority when start_div and start_mul are both set.
//  IDLE + start_div (T):
//    - Latch |op_a| and |op_b|. Absolute values are taken only if signed_op=1.
//    - Latch the quotient/remainder sign bits and the signed_op flag.
//    - Go to DIV_RUN; counter=0.
//  Divide by zero, detected at T: no divider iteration. Go to DONE with lo=32'hFFFF_FFFF, hi=op_a.
//  DIV_RUN: restoring radix-2, one bit per cycle.
//    - Datapath: {rem,quo} shifted left; 33-bit trial subtract rem-divisor.
//    - WIDTH iterations, then DONE.
//  IDLE + start_mul (T): latch operands and signs as for div; go to MUL_RUN.
//  MUL_RUN: shift-add, one multiplier bit per cycle, sharing the same 33-bit adder.
//    WIDTH iterations, then DONE.
//  DONE:
//    - Sign fix-up applied. Quotient is negated if the operand signs differ.
//    - Remainder takes the dividend sign. Product is negated if the signs differ.
//    - result_valid=1 and stallreq=0 in this cycle; next state is IDLE unconditionally.
//  Latency: accept at T, result_valid at T+WIDTH+1 (T+33). Div-by-zero: T+1.
//  stallreq = start_accept_in_IDLE | DIV_RUN | MUL_RUN.
//    - Combinational in the accept cycle so EX freezes immediately.
//    - Deasserted in DONE.
//  busy = DIV_RUN | MUL_RUN.
//  annul in any state: next state IDLE; no result_valid; counter cleared.
//    - stallreq drops in the same cycle.
//    - annul together with start in IDLE: start is not accepted.
//  result_hi/lo hold their last value outside DONE. Consumers qualify with result_valid.
//  Width rule: signed -2^31 / -1 gives lo=32'h8000_0000, hi=0 (wraps, no trap).
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    - mult/multu use a single-cycle 64-bit multiply: IDLE -> DONE, result_valid at T+1.
//    - MUL_RUN is unused; stallreq is asserted only in the accept cycle.
//  MULDIV_FAST_MUL_EN undefined: iterative MUL_RUN as above, T+33. Divide is unaffected either way.
// STRUCTURE
//  lib/defines.vh holds the shared constants: `StallBus, `Stop/`NoStop, MD_ST_* state encodings,
//    MD_ITER (=32).
//  One sub-module: md_iter_core.
//    - Contents: 65-bit shift register, shared 33-bit adder/subtractor, step/mode inputs.
//    - Interface: step, mode(div/mul), load, operands in; {hi,lo} raw out.
//  muldiv_seq keeps the FSM, counter, sign latch, sign fix-up and stallreq logic.
// TESTING
//  1. divu op_a=100, op_b=7 -> stallreq for 33 cycles; result_valid at T+33; lo=14, hi=2.
//  2. div op_a=-7 (32'hFFFF_FFF9), op_b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
//  3. mult op_a=32'hFFFF_FFFF (-1), op_b=3 -> {hi,lo}=64'hFFFF_FFFF_FFFF_FFFD.
//       Latency is T+33 (T+1 with MULDIV_FAST_MUL_EN).
//  4. annul asserted at T+10 of a div -> state IDLE next cycle; no result_valid pulse.
//       stallreq=0 in the annul cycle; a new start 2 cycles later completes normally.
//  5. divu op_b=0, op_a=5 -> result_valid at T+1; lo=32'hFFFF_FFFF, hi=5.
//  6. start_div held through DONE, then a back-to-back multu in EX the next cycle:
//       - exactly one div result is produced;
//       - the multu is accepted in the IDLE cycle after DONE;
//       - rst mid-run clears every output the next cycle.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared states, modes and sizes for the HI/LO multiply/divide sequencer
package muldiv_seq_pkg;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      MD_ST_IDLE    = 2'd0,
      MD_ST_DIV_RUN = 2'd1,
      MD_ST_MUL_RUN = 2'd2,
      MD_ST_DONE    = 2'd3
   } md_state_t;

   typedef enum logic {
      MD_MODE_MUL = 1'b0,
      MD_MODE_DIV = 1'b1
   } md_mode_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-side request/result bundle of the multiply/divide sequencer
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start_div;
   logic             start_mul;
   logic             signed_op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             annul;
   logic             stallreq;
   logic             busy;
   logic             result_valid;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;

   modport master (
      output start_div, start_mul, signed_op, op_a, op_b, annul,
      input  stallreq, busy, result_valid, result_hi, result_lo
   );

   modport slave (
      input  start_div, start_mul, signed_op, op_a, op_b, annul,
      output stallreq, busy, result_valid, result_hi, result_lo
   );
endinterface

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - shift register plus one shared 33-bit adder: restoring divide or shift-add multiply
// Div keeps {rem,quo} and shifts left; mul keeps {hi,multiplier} and shifts right.
module md_iter_core
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_ITER
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               load_raw,
   input  logic               step,
   input  md_mode_t           mode,
   input  logic [WIDTH-1:0]   lo_in,
   input  logic [WIDTH-1:0]   opnd_in,
   input  logic [2*WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH:0]     add_a;
   logic [WIDTH:0]     add_b;
   logic               add_cin;
   logic [WIDTH+1:0]   sum;
   logic               no_borrow;

   // Divide subtracts via a + ~b + 1; the carry out doubles as "remainder >= divisor".
   always_comb begin
      if (mode == MD_MODE_DIV) begin
         add_a   = acc[2*WIDTH-1:WIDTH-1];
         add_b   = ~{1'b0, opnd};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
         add_b   = acc[0] ? {1'b0, opnd} : '0;
         add_cin = 1'b0;
      end
      sum       = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
      no_borrow = sum[WIDTH+1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         opnd <= '0;
      end else if (load_raw) begin
         acc <= raw_in;
      end else if (load) begin
         acc  <= {{WIDTH{1'b0}}, lo_in};
         opnd <= opnd_in;
      end else if (step) begin
         if (mode == MD_MODE_DIV) begin
            acc <= {(no_borrow ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                    acc[WIDTH-2:0], no_borrow};
         end else begin
            acc <= {sum[WIDTH:0], acc[WIDTH-1:1]};
         end
      end
   end

   assign hi = acc[2*WIDTH-1:WIDTH];
   assign lo = acc[WIDTH-1:0];
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - FSM, counter, sign handling and stall control for mult/multu/div/divu
// MULDIV_FAST_MUL_EN: single-cycle multiply instead of the iterative MUL_RUN.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_ITER,
   parameter int CNT_W = 6
) (
   input logic         clk,
   input logic         rst,
   muldiv_seq_if.slave bus
);
   md_state_t          state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, dz, neg_q, neg_r;
   logic [WIDTH-1:0]   held_hi, held_lo;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic               accept, running, last_iter;
   logic               core_load, core_load_raw, core_step;
   md_mode_t           core_mode;
   logic [WIDTH-1:0]   core_lo_in, core_opnd_in;
   logic [2*WIDTH-1:0] core_raw_in;
   logic [WIDTH-1:0]   raw_hi, raw_lo;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic               valid;

   assign a_abs     = (bus.signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
   assign b_abs     = (bus.signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
   assign accept    = (state == MD_ST_IDLE) && (bus.start_div || bus.start_mul) && !bus.annul;
   assign running   = (state == MD_ST_DIV_RUN) || (state == MD_ST_MUL_RUN);
   assign last_iter = (cnt == CNT_W'(WIDTH-1));
   assign valid     = (state == MD_ST_DONE) && !bus.annul;

   always_comb begin
      state_nx      = state;
      core_load     = 1'b0;
      core_load_raw = 1'b0;
      core_step     = 1'b0;
      core_mode     = is_div ? MD_MODE_DIV : MD_MODE_MUL;
      core_lo_in    = a_abs;
      core_opnd_in  = b_abs;
      core_raw_in   = '0;
      case (state)
         MD_ST_IDLE: begin
            if (accept) begin
               if (bus.start_div) begin
                  if (bus.op_b == '0) begin
                     // Divide by zero skips the engine: {hi,lo} = {op_a, all ones}.
                     core_load_raw = 1'b1;
                     core_raw_in   = {bus.op_a, {WIDTH{1'b1}}};
                     state_nx      = MD_ST_DONE;
                  end else begin
                     core_load = 1'b1;
                     state_nx  = MD_ST_DIV_RUN;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  core_load_raw = 1'b1;
                  core_raw_in   = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
                  state_nx      = MD_ST_DONE;
`else
                  core_load    = 1'b1;
                  core_lo_in   = b_abs;
                  core_opnd_in = a_abs;
                  state_nx     = MD_ST_MUL_RUN;
`endif
               end
            end
         end
         MD_ST_DIV_RUN, MD_ST_MUL_RUN: begin
            core_step = 1'b1;
            if (last_iter) state_nx = MD_ST_DONE;
         end
         MD_ST_DONE: state_nx = MD_ST_IDLE;
         default:    state_nx = MD_ST_IDLE;
      endcase
      if (bus.annul) begin
         state_nx      = MD_ST_IDLE;
         core_load     = 1'b0;
         core_load_raw = 1'b0;
         core_step     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MD_ST_IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         dz      <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         held_hi <= '0;
         held_lo <= '0;
      end else begin
         state <= state_nx;
         if (bus.annul || accept || (core_step && last_iter)) cnt <= '0;
         else if (core_step) cnt <= cnt + 1'b1;
         if (accept) begin
            is_div <= bus.start_div;
            dz     <= bus.start_div && (bus.op_b == '0);
            neg_q  <= bus.signed_op && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            neg_r  <= bus.signed_op && bus.op_a[WIDTH-1];
         end
         if (valid) begin
            held_hi <= fix_hi;
            held_lo <= fix_lo;
         end
      end
   end

   always_comb begin
      fix_hi = raw_hi;
      fix_lo = raw_lo;
      if (!dz) begin
         if (is_div) begin
            if (neg_q) fix_lo = -raw_lo;
            if (neg_r) fix_hi = -raw_hi;
         end else if (neg_q) begin
            {fix_hi, fix_lo} = -{raw_hi, raw_lo};
         end
      end
   end

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .load_raw(core_load_raw),
      .step    (core_step),
      .mode    (core_mode),
      .lo_in   (core_lo_in),
      .opnd_in (core_opnd_in),
      .raw_in  (core_raw_in),
      .hi      (raw_hi),
      .lo      (raw_lo)
   );

   assign bus.stallreq     = !bus.annul && (accept || running);
   assign bus.busy         = running;
   assign bus.result_valid = valid;
   assign bus.result_hi    = valid ? fix_hi : held_hi;
   assign bus.result_lo    = valid ? fix_lo : held_lo;
endmodule
